alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter sharing the single combinational EXE-stage ALU between two requesters (pipeline EXE stage and an auxiliary address/compare unit). Grants at most one request per cycle, drives the ALU operand/command bus, registers the result and NZCV into a one-deep response slot, and keeps a per-requester NZCV flag register whose C bit feeds the ALU carry input.

## Interface
- `WIDTH`, 32: operand/result width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: request valid per requester.
- `req_ready` out 2: request accepted this edge when `req_valid[i] & req_ready[i]`.
- `req_val1` / `req_val2` in 2×WIDTH: operands per requester.
- `req_cmd` in 2×4: EXE_CMD per requester (ALU encoding).
- `req_s` in 2: update that requester's flags with result status.
- `req_lock` in 2: hold grant for the next request (only with `ALU_ARB_LOCK_EN`).
- `alu_value1`, `alu_value2` out WIDTH; `alu_carryIn` out 1; `alu_EXE_CMD` out 4: to ALU.
- `alu_result` in WIDTH; `alu_status` in 4 ({N,Z,C,V}): from ALU, same cycle.
- `resp_valid` out 1; `resp_ready` in 1; `resp_id` out 1; `resp_result` out WIDTH; `resp_status` out 4.
- `flags0`, `flags1` out 4: per-requester NZCV registers.

## Operation
- Response slot FSM: EMPTY, FULL. `slot_free = EMPTY | (FULL & resp_ready)`.
- Arbitration (combinational): candidate = valid requesters; if both valid, grant the one not equal to `last_q`; if one valid, grant it. `req_ready[i] = grant[i] & slot_free`; at most one bit set.
- ALU bus driven from granted requester; when no grant, drive zeros and `alu_EXE_CMD = 0` (ALU default case).
- `alu_carryIn = flagsN[1]` (C bit) of the granted requester.
- On accept: slot ← {id, alu_result, alu_status}, state FULL; `last_q` ← id; if `req_s[id]`, `flags[id]` ← `alu_status`. Other requester's flags untouched.
- FULL & resp_ready & no accept → EMPTY. FULL & resp_ready & accept → FULL with new contents. FULL & !resp_ready → hold, `req_ready = 0`.
- Reset: state EMPTY, `resp_valid=0`, `resp_id=0`, `resp_result=0`, `resp_status=0`, `flags0=flags1=0`, `last_q=1` (requester 0 wins first tie), lock cleared.

## Timing
- Accept at edge k → `resp_valid` high from k (visible cycle k+1); latency 1.
- Throughput one op/cycle with `resp_ready` held high; alternates 0,1,0,1 under continuous contention.
- Flag update visible at the next accept, so back-to-back ADC/SBC from one requester chains carry with no bubble.
- Requester must hold valid/operands stable until accepted; arbiter may switch grant between cycles while not accepted (non-locked).
- `rst` mid-operation discards a FULL slot and any lock; no response emitted for it.

## Configuration
- `ALU_ARB_LOCK_EN` defined: accepting a request with `req_lock[id]=1` sets `lock_q`/`lock_id`; while locked only `lock_id` can be granted (other requester stalls even if valid); lock clears on accepting a request from `lock_id` with `req_lock=0`. Used for multi-word carry chains.
- Undefined: `req_lock` ignored, no lock state; pure round-robin.

## Structure
- Shared package `alu_arb_pkg`: EXE_CMD localparams (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000), flag bit indices (N=3, Z=2, C=1, V=0), slot state enum.
- One sub-module natural: `rr_arb2` (two-way round-robin grant with optional lock). ALU instantiated outside.

## Test plan
- Single req0: ADD 5+7, `req_s=1` → next cycle `resp_valid=1`, id 0, result 12, status 0000, `flags0=0000`.
- Both valid continuous, `resp_ready=1` → ids 0,1,0,1, one grant per cycle, never both `req_ready`.
- Carry chain req0: ADD 0xFFFFFFFF+1 S=1 then ADC 0+0 → results 0 (status 0110) then 1; `flags1` unchanged.
- Backpressure: `resp_ready=0` 3 cycles with slot FULL → `req_ready=00`, response held stable; release → drains and accepts same edge.
- `ALU_ARB_LOCK_EN`: req0 lock=1 while req1 valid → req1 stalls until req0 issues lock=0; without macro → alternation.
- `rst` asserted with FULL slot and flags 1111 → next cycle all outputs zero, req0 granted first.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the two-requester ALU arbiter.
// Holds the ALU EXE_CMD encodings, NZCV flag bit positions, the
// response-slot state type and a small id-to-one-hot helper.
package alu_arb_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned NZCV_W = 4;
    localparam int unsigned NREQ   = 2;

    // ALU command encodings
    localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;

    // NZCV bit positions inside a status nibble
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Requester id to one-hot grant vector
    function automatic logic [NREQ-1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant with optional lock.
// Ports:
//   valid       - request valid per requester
//   last_id     - requester granted last; the other one wins a tie
//   lock_active - when set, only lock_id may be granted
//   lock_id     - requester holding the lock
//   grant       - one-hot grant (zero when nobody eligible)
//   grant_id    - index of the granted requester (0 when no grant)
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic            last_id,
    input  logic            lock_active,
    input  logic            lock_id,
    output logic [NREQ-1:0] grant,
    output logic            grant_id
);

    logic [NREQ-1:0] cand;

    // Mask to the lock holder, then pick the non-last requester on a tie
    always_comb begin
        cand     = valid;
        grant    = '0;
        grant_id = 1'b0;
        if (lock_active) begin
            cand = valid & id_to_onehot(lock_id);
        end
        if (cand == 2'b11) begin
            grant_id = ~last_id;
        end else begin
            grant_id = cand[1];
        end
        if (|cand) begin
            grant = id_to_onehot(grant_id);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Grants at most one request per cycle in round-robin order, drives the
// ALU operand/command bus from the granted requester, captures the ALU
// result and NZCV into a one-deep response slot and maintains a NZCV
// register per requester whose C bit feeds the ALU carry input.
// Optional feature macro: ALU_ARB_LOCK_EN (grant lock for multi-word chains).
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid/req_ready            - per-requester handshake
//   req_val1/req_val2/req_cmd      - per-requester operands and EXE_CMD
//   req_s                          - update that requester's flags
//   req_lock                       - hold grant (lock build only)
//   alu_value1/2, alu_carryIn,
//   alu_EXE_CMD                    - to the external ALU
//   alu_result, alu_status         - from the external ALU (same cycle)
//   resp_valid/resp_ready, resp_id,
//   resp_result, resp_status       - response slot
//   flags0, flags1                 - per-requester NZCV registers
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0] req_val1,
    input  logic [NREQ-1:0][WIDTH-1:0] req_val2,
    input  logic [NREQ-1:0][CMD_W-1:0] req_cmd,
    input  logic [NREQ-1:0]            req_s,
    input  logic [NREQ-1:0]            req_lock,
    output logic [WIDTH-1:0]           alu_value1,
    output logic [WIDTH-1:0]           alu_value2,
    output logic                       alu_carryIn,
    output logic [CMD_W-1:0]           alu_EXE_CMD,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic [NZCV_W-1:0]          alu_status,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_id,
    output logic [WIDTH-1:0]           resp_result,
    output logic [NZCV_W-1:0]          resp_status,
    output logic [NZCV_W-1:0]          flags0,
    output logic [NZCV_W-1:0]          flags1
);

    slot_state_e                   state_q;
    logic                          resp_id_q;
    logic [WIDTH-1:0]              resp_result_q;
    logic [NZCV_W-1:0]             resp_status_q;
    logic [NREQ-1:0][NZCV_W-1:0]   flags_q;
    logic                          last_q;
    logic                          lock_q;
    logic                          lock_id_q;

    logic [NREQ-1:0]               grant;
    logic                          grant_id;
    logic                          any_grant;
    logic                          slot_free;
    logic                          accept;

    rr_arb2 u_rr_arb2 (
        .valid       (req_valid),
        .last_id     (last_q),
        .lock_active (lock_q),
        .lock_id     (lock_id_q),
        .grant       (grant),
        .grant_id    (grant_id)
    );

    assign any_grant = |grant;
    // Slot can take a new result if empty or being drained this edge
    assign slot_free = (state_q == SLOT_EMPTY) || resp_ready;
    assign req_ready = grant & {NREQ{slot_free}};
    assign accept    = |req_ready;

    // ALU bus: granted requester's operands, zeros / default command when idle
    always_comb begin
        alu_value1  = '0;
        alu_value2  = '0;
        alu_EXE_CMD = EXE_NOP;
        alu_carryIn = 1'b0;
        if (any_grant) begin
            alu_value1  = req_val1[grant_id];
            alu_value2  = req_val2[grant_id];
            alu_EXE_CMD = req_cmd[grant_id];
            alu_carryIn = flags_q[grant_id][FLAG_C];
        end
    end

    // Response slot, round-robin pointer and per-requester flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SLOT_EMPTY;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_status_q <= '0;
            flags_q       <= '0;
            last_q        <= 1'b1;
        end else begin
            if (accept) begin
                state_q       <= SLOT_FULL;
                resp_id_q     <= grant_id;
                resp_result_q <= alu_result;
                resp_status_q <= alu_status;
                last_q        <= grant_id;
                if (req_s[grant_id]) begin
                    flags_q[grant_id] <= alu_status;
                end
            end else if ((state_q == SLOT_FULL) && resp_ready) begin
                state_q <= SLOT_EMPTY;
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // Lock follows the req_lock bit of every accepted request; while held,
    // only the holder can be granted, so only the holder can release it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else if (accept) begin
            lock_q    <= req_lock[grant_id];
            lock_id_q <= grant_id;
        end
    end
`else
    logic unused_req_lock;
    assign unused_req_lock = ^req_lock;
    assign lock_q          = 1'b0;
    assign lock_id_q       = 1'b0;
`endif

    assign resp_valid  = (state_q == SLOT_FULL);
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_status = resp_status_q;
    assign flags0      = flags_q[0];
    assign flags1      = flags_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Provides a behavioural
// ALU, directed scenarios and randomized traffic compared against a
// transaction-level reference model of the arbiter.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned W = 32;
`ifdef ALU_ARB_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][W-1:0] req_val1;
    logic [1:0][W-1:0] req_val2;
    logic [1:0][3:0]   req_cmd;
    logic [1:0]        req_s;
    logic [1:0]        req_lock;
    logic [W-1:0]      alu_value1;
    logic [W-1:0]      alu_value2;
    logic              alu_carryIn;
    logic [3:0]        alu_EXE_CMD;
    logic [W-1:0]      alu_result;
    logic [3:0]        alu_status;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [W-1:0]      resp_result;
    logic [3:0]        resp_status;
    logic [3:0]        flags0;
    logic [3:0]        flags1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_val1    (req_val1),
        .req_val2    (req_val2),
        .req_cmd     (req_cmd),
        .req_s       (req_s),
        .req_lock    (req_lock),
        .alu_value1  (alu_value1),
        .alu_value2  (alu_value2),
        .alu_carryIn (alu_carryIn),
        .alu_EXE_CMD (alu_EXE_CMD),
        .alu_result  (alu_result),
        .alu_status  (alu_status),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_status (resp_status),
        .flags0      (flags0),
        .flags1      (flags1)
    );

    // ARM-style ALU: returns {result, N, Z, C, V}
    function automatic logic [W+3:0] alu_fn(input logic [3:0] cmd, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0]   w;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (cmd)
            EXE_MOV: r = b;
            EXE_MVN: r = ~b;
            EXE_ADD, EXE_ADC: begin
                w = {1'b0, a} + {1'b0, b} + ((cmd == EXE_ADC) ? 33'(cin) : 33'd0);
                r = w[W-1:0]; c = w[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            EXE_SUB, EXE_SBC: begin
                w = {1'b0, a} + {1'b0, ~b} + ((cmd == EXE_SUB) ? 33'd1 : 33'(cin));
                r = w[W-1:0]; c = w[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            EXE_AND: r = a & b;
            EXE_ORR: r = a | b;
            EXE_EOR: r = a ^ b;
            default: r = '0;
        endcase
        return {r, r[W-1], (r == '0), c, v};
    endfunction

    always_comb begin
        logic [W+3:0] o;
        o = alu_fn(alu_EXE_CMD, alu_value1, alu_value2, alu_carryIn);
        alu_result = o[W+3:4];
        alu_status = o[3:0];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit         m_full, m_id, m_last, m_lock, m_lock_id;
    logic [W-1:0] m_result;
    logic [3:0] m_status;
    logic [3:0] m_flags [2];
    bit         acc, acc_id;
    bit         rand_lock = 1'b0;

    function automatic logic [3:0] pick_cmd(input int k);
        case (k)
            0: return EXE_MOV; 1: return EXE_MVN; 2: return EXE_ADD;
            3: return EXE_ADC; 4: return EXE_SUB; 5: return EXE_SBC;
            6: return EXE_AND; 7: return EXE_ORR; default: return EXE_EOR;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_op(input int id, input logic [3:0] cmd, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit s, input bit lk);
        req_valid[id] = 1'b1;
        req_cmd[id]   = cmd;
        req_val1[id]  = a;
        req_val2[id]  = b;
        req_s[id]     = s;
        req_lock[id]  = lk;
    endtask

    task automatic new_op(input int id);
        set_op(id, pick_cmd($urandom_range(0, 8)), rand_val(), rand_val(),
               1'($urandom_range(0, 1)), rand_lock && ($urandom_range(0, 2) == 0));
    endtask

    task automatic model_reset();
        m_full = 0; m_id = 0; m_last = 1; m_lock = 0; m_lock_id = 0;
        m_result = '0; m_status = '0;
        m_flags[0] = '0; m_flags[1] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_status", 32'(resp_status), 32'd0);
        check("rst_flags0", 32'(flags0), 32'd0);
        check("rst_flags1", 32'(flags1), 32'd0);
    endtask

    // One cycle: predict the handshake before the edge, check state after it
    task automatic step(input bit refill);
        bit c0, c1, any, g, free;
        logic [1:0]   exp_ready;
        logic [W+3:0] o;
        @(negedge clk);
        c0 = req_valid[0];
        c1 = req_valid[1];
        if (LOCK_BUILD && m_lock) begin
            if (m_lock_id) c0 = 0; else c1 = 0;
        end
        any = c0 | c1;
        g   = (c0 && c1) ? ~m_last : c1;
        free = !m_full || resp_ready;
        exp_ready = 2'b00;
        if (any && free) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("alu_cmd", 32'(alu_EXE_CMD), any ? 32'(req_cmd[g]) : 32'd0);
        check("alu_cin", 32'(alu_carryIn), any ? 32'(m_flags[g][1]) : 32'd0);
        acc = any && free;
        acc_id = g;
        if (acc) begin
            o = alu_fn(req_cmd[g], req_val1[g], req_val2[g], m_flags[g][1]);
            m_full = 1; m_id = g; m_result = o[W+3:4]; m_status = o[3:0]; m_last = g;
            if (req_s[g]) m_flags[g] = o[3:0];
            if (LOCK_BUILD) begin m_lock = req_lock[g]; m_lock_id = g; end
        end else if (m_full && resp_ready) begin
            m_full = 0;
        end
        @(posedge clk); #1;
        check("resp_valid", 32'(resp_valid), 32'(m_full));
        if (m_full) begin
            check("resp_id", 32'(resp_id), 32'(m_id));
            check("resp_result", resp_result, m_result);
            check("resp_status", 32'(resp_status), 32'(m_status));
        end
        check("flags0", 32'(flags0), 32'(m_flags[0]));
        check("flags1", 32'(flags1), 32'(m_flags[1]));
        if (acc) begin
            if (refill) new_op(int'(acc_id));
            else req_valid[acc_id] = 1'b0;
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1; resp_ready = 1'b1;
        req_valid = '0; req_val1 = '0; req_val2 = '0; req_cmd = '0; req_s = '0; req_lock = '0;
        model_reset();
        do_reset();

        // Single request ADD 5+7
        set_op(0, EXE_ADD, 32'd5, 32'd7, 1'b1, 1'b0);
        step(1'b0);
        check("add_valid", 32'(resp_valid), 32'd1);
        check("add_id", 32'(resp_id), 32'd0);
        check("add_result", resp_result, 32'd12);
        check("add_status", 32'(resp_status), 32'd0);
        step(1'b0);

        // Continuous contention: strict alternation, last winner was 0
        new_op(0); new_op(1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("alt_id", 32'(resp_id), 32'(i % 2 == 0));
        end
        req_valid = '0;
        step(1'b0);

        // Carry chain on requester 0
        set_op(0, EXE_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        step(1'b0);
        check("chain_add_result", resp_result, 32'd0);
        check("chain_add_status", 32'(resp_status), 32'h6);
        check("chain_flags0", 32'(flags0), 32'h6);
        set_op(0, EXE_ADC, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0);
        check("chain_adc_result", resp_result, 32'd1);
        step(1'b0);

        // Backpressure with a full slot
        set_op(0, EXE_MOV, 32'd0, 32'h1234, 1'b0, 1'b0);
        step(1'b0);
        resp_ready = 1'b0;
        set_op(0, EXE_EOR, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0);
        set_op(1, EXE_ORR, 32'h1, 32'h2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_hold", resp_result, 32'h1234);
        end
        resp_ready = 1'b1;
        step(1'b0);
        check("bp_release_id", 32'(resp_id), 32'd1);
        check("bp_release_result", resp_result, 32'h3);
        req_valid = '0;
        step(1'b0);

        // Lock: requester 0 issues three locked ops then one unlocking op
        n0 = 0;
        set_op(1, EXE_SUB, 32'd9, 32'd4, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (!req_valid[0] && n0 < 4) begin
                set_op(0, EXE_ADC, W'($urandom), W'($urandom), 1'b1, n0 < 3);
                n0++;
            end
            step(1'b0);
        end

        // Reset with a full slot discards it; requester 0 wins first tie
        new_op(0); new_op(1);
        step(1'b0);
        req_valid = '0;
        do_reset();
        new_op(0); new_op(1);
        step(1'b0);
        check("post_rst_id", 32'(resp_id), 32'd0);
        req_valid = '0;
        step(1'b0);

        // Randomized traffic
        rand_lock = 1'b1;
        for (int i = 0; i < 500; i++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(0, 1) == 1) new_op(r);
            end
            if ($urandom_range(0, 199) == 0) begin
                req_valid = '0;
                do_reset();
            end else begin
                step(1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
